serialize_16bit: RTL and testbench

SERIALIZE_16BIT -- requirements
Module: serialize_16bit

---
 rtl/serialize_16bit_pkg.sv | 30 +++
 rtl/serialize_16bit_down_counter_n.sv | 48 ++++
 rtl/serialize_16bit_flop.sv | 36 +++
 rtl/serialize_16bit.sv | 133 +++++++++++++
 tb/tb_serialize_16bit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serialize_16bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serialize_16bit_pkg
// Description : Shared definitions for the word serializer.
//               - Default data width and index width.
//               - Serializer state encoding (IDLE, SHIFT, DONE).
//               - Helper that says whether a state drives a serial bit.
// Revision    : 1.0 - initial release
// ============================================================================
package serialize_16bit_pkg;

    // Default data word width and matching bit-index width (clog2 of width).
    localparam int unsigned C_W_DEFAULT     = 16;
    localparam int unsigned C_IDX_W_DEFAULT = 4;

    // Serializer states. The encoding is fixed so that the reset value
    // (all zeros) is IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_e;

    // True only in the state that presents bits to the downstream sink.
    function automatic logic is_shift_state(input ser_state_e st);
        return (st == SHIFT);
    endfunction

endpackage : serialize_16bit_pkg
`default_nettype wire

// File: rtl/serialize_16bit_down_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_n
// Description : WIDTH-bit loadable down counter that saturates at zero.
//               Load has priority over decrement. The zero flag is decoded
//               from the registered count only.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous clear, active low (count -> 0)
//               i_load     - load i_load_val into the count
//               i_load_val - value to load
//               i_en       - decrement enable (ignored when count is 0)
//               o_count    - current count
//               o_zero     - count equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;
    logic             w_zero;

    assign w_zero = (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_zero) begin
            // Saturating: a decrement request at zero leaves the count at 0.
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = w_zero;

endmodule : down_counter_n
`default_nettype wire

// File: rtl/serialize_16bit_flop.sv
`default_nettype none
// ============================================================================
// Module      : dff_en_rn
// Description : Parameterized flop library cell: WIDTH-bit register with a
//               load enable and an asynchronous active-low clear.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous clear, active low (clears to 0)
//               i_en   - load enable
//               i_d    - data in
//               o_q    - registered data out
// Revision    : 1.0 - initial release
// ============================================================================
module dff_en_rn #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : dff_en_rn
`default_nettype wire

// File: rtl/serialize_16bit.sv
`default_nettype none
// ============================================================================
// Module      : serialize_16bit
// Description : Serializes bits len_i down to 0 of a captured word, highest
//               index first, with a valid/ready handshake on the bit stream
//               and a one-cycle done pulse after the final bit is accepted.
// Ports       : clk_i        - rising-edge clock
//               rst_i        - asynchronous reset, active low
//               data_i       - word to serialize (captured on start)
//               len_i        - index of the highest bit to send
//               start_i      - request strobe, honoured only in IDLE
//               bit_ready_i  - downstream accepts bit_o this cycle
//               busy_o       - block is not idle
//               bit_o        - current serial bit
//               bit_valid_o  - bit_o is valid
//               last_o       - bit_o is index 0 (final bit of the word)
//               done_o       - one-cycle pulse after the final bit
// Revision    : 1.0 - initial release
// ============================================================================
module serialize_16bit
    import serialize_16bit_pkg::*;
#(
    parameter int W     = C_W_DEFAULT,
    parameter int IDX_W = C_IDX_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [W-1:0]     data_i,
    input  logic [IDX_W-1:0] len_i,
    input  logic             start_i,
    input  logic             bit_ready_i,
    output logic             busy_o,
    output logic             bit_o,
    output logic             bit_valid_o,
    output logic             last_o,
    output logic             done_o
);

    ser_state_e       r_state;
    ser_state_e       w_state_next;
    logic             w_capture;
    logic             w_dec;
    logic [W-1:0]     r_data_q;
    logic [IDX_W-1:0] r_cnt_q;
    logic             w_cnt_zero;
    logic             w_in_shift;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_dec        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_capture    = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_ready_i) begin
                    if (w_cnt_zero) begin
                        w_state_next = DONE;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word register: written only on an accepted start, so a start pulse
    // that arrives while busy cannot disturb the word in flight.
    // ------------------------------------------------------------------
    dff_en_rn #(
        .WIDTH (W)
    ) u_data_reg (
        .clk   (clk_i),
        .rst_n (rst_i),
        .i_en  (w_capture),
        .i_d   (data_i),
        .o_q   (r_data_q)
    );

    // ------------------------------------------------------------------
    // Bit index counter: starts at len_i and walks down to 0.
    // ------------------------------------------------------------------
    down_counter_n #(
        .WIDTH (IDX_W)
    ) u_bit_cnt (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .i_load     (w_capture),
        .i_load_val (len_i),
        .i_en       (w_dec),
        .o_count    (r_cnt_q),
        .o_zero     (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state, count and word only, so no
    // input reaches an output combinationally and reset clears them all
    // immediately through the asynchronous clears.
    // ------------------------------------------------------------------
    assign w_in_shift  = is_shift_state(r_state);
    assign busy_o      = (r_state != IDLE);
    assign bit_valid_o = w_in_shift;
    assign bit_o       = w_in_shift & r_data_q[r_cnt_q];
    assign last_o      = w_in_shift & w_cnt_zero;
    assign done_o      = (r_state == DONE);

endmodule : serialize_16bit
`default_nettype wire

// File: tb/tb_serialize_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serialize_16bit
// Description : Self-checking bench for serialize_16bit. Each word's expected
//               bit stream is built as a queue from the word and its length;
//               the bench drives random handshakes and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serialize_16bit;

    localparam int W     = 16;
    localparam int IDX_W = 4;

    // Ready patterns for run_word
    localparam int C_MODE_ALWAYS = 0;
    localparam int C_MODE_RANDOM = 1;
    localparam int C_MODE_STALL  = 2;
    localparam int C_MODE_COLLIDE = 3;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic [W-1:0]     data_i = '0;
    logic [IDX_W-1:0] len_i = '0;
    logic             start_i = 1'b0;
    logic             bit_ready_i = 1'b0;
    logic             busy_o;
    logic             bit_o;
    logic             bit_valid_o;
    logic             last_o;
    logic             done_o;

    int n_checks = 0;
    int n_errors = 0;

    serialize_16bit #(
        .W     (W),
        .IDX_W (IDX_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .len_i       (len_i),
        .start_i     (start_i),
        .bit_ready_i (bit_ready_i),
        .busy_o      (busy_o),
        .bit_o       (bit_o),
        .bit_valid_o (bit_valid_o),
        .last_o      (last_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {busy, bit, valid, last, done} must all be zero when idle or in reset.
    task automatic check_quiet(input string tag);
        check_eq(tag, 32'({busy_o, bit_o, bit_valid_o, last_o, done_o}), 32'd0);
    endtask

    // Sends one word and checks the full bit stream, the done pulse and the
    // return to idle. Called and returns on a falling edge.
    task automatic run_word(input logic [W-1:0] data, input int len, input int mode);
        bit exp_q[$];
        int k;
        int cyc;
        int stall;
        int nbits;
        logic rdy;

        exp_q.delete();
        for (int i = len; i >= 0; i--) exp_q.push_back(data[i]);
        nbits = exp_q.size();
        k = 0;
        cyc = 0;
        stall = 0;

        @(negedge clk);
        data_i      = data;
        len_i       = len[IDX_W-1:0];
        start_i     = 1'b1;
        bit_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;

        while (k < nbits && cyc < 300) begin
            check_eq("bit_valid", 32'(bit_valid_o), 32'd1);
            check_eq("busy_shift", 32'(busy_o), 32'd1);
            check_eq("bit", 32'(bit_o), 32'(exp_q[k]));
            check_eq("last", 32'(last_o), 32'(k == nbits - 1));
            check_eq("done_in_shift", 32'(done_o), 32'd0);
            case (mode)
                C_MODE_ALWAYS: rdy = 1'b1;
                C_MODE_STALL: begin
                    if (k == 4 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                C_MODE_COLLIDE: begin
                    rdy     = 1'($urandom_range(0, 1));
                    start_i = 1'($urandom_range(0, 1));
                    data_i  = 16'hFFFF;
                    len_i   = 4'hF;
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bit_ready_i = rdy;
            if (rdy) k++;
            cyc++;
            @(negedge clk);
        end
        check_eq("bits_sent", 32'(k), 32'(nbits));

        // DONE cycle: start is still ignored here in collide mode.
        check_eq("done_pulse", 32'(done_o), 32'd1);
        check_eq("busy_done", 32'(busy_o), 32'd1);
        check_eq("valid_done", 32'({bit_valid_o, bit_o, last_o}), 32'd0);
        bit_ready_i = 1'($urandom_range(0, 1));
        if (mode != C_MODE_COLLIDE) start_i = 1'b0;
        @(negedge clk);
        check_quiet("idle_after_done");
        start_i     = 1'b0;
        bit_ready_i = 1'b0;
        @(negedge clk);
        check_quiet("no_queued_start");
    endtask

    // Starts a full-width word, then pulls reset asynchronously on bit 5.
    task automatic run_reset_abort(input logic [W-1:0] data);
        @(negedge clk);
        data_i      = data;
        len_i       = 4'd15;
        start_i     = 1'b1;
        bit_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("abort_pre_bit", 32'(bit_o), 32'(data[15-k]));
            @(negedge clk);
        end
        check_eq("abort_valid_b5", 32'(bit_valid_o), 32'd1);
        #2 rst_i = 1'b0;
        #1 check_quiet("abort_async_clear");
        @(negedge clk);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("abort_no_done");
        end
    endtask

    initial begin
        #1 check_quiet("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_quiet("reset_hold");
        rst_i = 1'b1;
        @(negedge clk);
        check_quiet("reset_release");

        run_word(16'h8001, 15, C_MODE_ALWAYS);
        run_word(16'h0005, 2,  C_MODE_ALWAYS);
        run_word(16'h0001, 0,  C_MODE_ALWAYS);
        run_word(16'h00A5, 7,  C_MODE_STALL);
        run_word(16'h0000, 9,  C_MODE_ALWAYS);
        run_word(16'h1234, 15, C_MODE_COLLIDE);
        run_word(16'h0000, 0,  C_MODE_COLLIDE);

        for (int n = 0; n < 30; n++) begin
            run_word(16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        run_reset_abort(16'hBEEF);
        run_word(16'h00A5, 7, C_MODE_RANDOM);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_serialize_16bit
`default_nettype wire
